// File: rtl/collision_score_if.sv
// Game-side bus for the collision/score block: run request, bird and pipe
// geometry in; play status and BCD scores out.
interface collision_score_if;
    logic        Start;
    logic [9:0]  BirdPosY;
    logic [9:0]  PipePosXA;
    logic [9:0]  PipePosYA;
    logic [9:0]  PipePosXB;
    logic [9:0]  PipePosYB;
    logic        Playing;
    logic        Lost;
    logic        ScoreTick;
    logic [15:0] Score;
    logic [15:0] HighScore;

    modport master (
        output Start, BirdPosY, PipePosXA, PipePosYA, PipePosXB, PipePosYB,
        input  Playing, Lost, ScoreTick, Score, HighScore
    );

    modport slave (
        input  Start, BirdPosY, PipePosXA, PipePosYA, PipePosXB, PipePosYB,
        output Playing, Lost, ScoreTick, Score, HighScore
    );
endinterface

// File: rtl/collision_score.sv
// Collision detection, pass counting and BCD score/high-score keeping for a
// two-pipe flappy-bird style game.
module collision_score #(
    parameter int unsigned BIRD_X    = 200,
    parameter int unsigned BIRD_SIZE = 20,
    parameter int unsigned PIPE_W    = 60,
    parameter int unsigned GAP_H     = 150,
    parameter int unsigned FLOOR_Y   = 480
) (
    input  logic             Clk,
    input  logic             Reset,
    collision_score_if.slave bus
);

    localparam logic [10:0] BX    = 11'(BIRD_X);
    localparam logic [10:0] BSZ   = 11'(BIRD_SIZE);
    localparam logic [10:0] PW    = 11'(PIPE_W);
    localparam logic [10:0] GH    = 11'(GAP_H);
    localparam logic [10:0] FLOOR = 11'(FLOOR_Y);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  prev_xa;
    logic [9:0]  prev_xb;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        score_tick;

    logic [10:0] by;
    logic        hit_a;
    logic        hit_b;
    logic        floor_hit;
    logic        collision;
    logic        pass_a;
    logic        pass_b;
    logic [15:0] score_inc1;
    logic [15:0] score_inc2;

    // Bird box overlaps pipe columns horizontally but lies outside the gap.
    function automatic logic pipe_hit(input logic [10:0] x, input logic [10:0] y,
                                      input logic [10:0] b);
        logic overlap;
        logic miss;
        overlap = (x < BX + BSZ) && (x + PW > BX);
        miss    = (b < y) || (b + BSZ > y + GH);
        return overlap && miss;
    endfunction

    // Pipe right edge moved from at/after the bird's left edge to before it;
    // a rightward jump is a wrap-around and never scores.
    function automatic logic pipe_pass(input logic [10:0] prev, input logic [10:0] x);
        return (prev + PW >= BX) && (x + PW < BX) && (x <= prev);
    endfunction

    // One saturating BCD step; 9999 stays 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign by         = {1'b0, bus.BirdPosY};
    assign hit_a      = pipe_hit({1'b0, bus.PipePosXA}, {1'b0, bus.PipePosYA}, by);
    assign hit_b      = pipe_hit({1'b0, bus.PipePosXB}, {1'b0, bus.PipePosYB}, by);
    assign floor_hit  = (by + BSZ >= FLOOR);
    assign collision  = hit_a || hit_b || floor_hit;
    assign pass_a     = pipe_pass({1'b0, prev_xa}, {1'b0, bus.PipePosXA});
    assign pass_b     = pipe_pass({1'b0, prev_xb}, {1'b0, bus.PipePosXB});
    assign score_inc1 = bcd_inc(score);
    assign score_inc2 = bcd_inc(score_inc1);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; collision takes priority over a Start drop in PLAY.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.Start) state_next = PLAY;
            PLAY: begin
                if (collision) begin
                    state_next = LOST;
                end else if (!bus.Start) begin
                    state_next = IDLE;
                end
            end
            LOST: if (!bus.Start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Previous pipe positions, sampled every edge for pass detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_xa <= '1;
            prev_xb <= '1;
        end else begin
            prev_xa <= bus.PipePosXA;
            prev_xb <= bus.PipePosXB;
        end
    end

    // Score, tick and high score; scoring only on a surviving PLAY edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score      <= '0;
            high_score <= '0;
            score_tick <= 1'b0;
        end else begin
            score_tick <= 1'b0;
            case (state)
                IDLE: if (bus.Start) score <= '0;
                PLAY: begin
                    if (collision) begin
                        if (score > high_score) high_score <= score;
                    end else if (bus.Start && (pass_a || pass_b) && (score != 16'h9999)) begin
                        score      <= (pass_a && pass_b) ? score_inc2 : score_inc1;
                        score_tick <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Playing   = (state == PLAY);
    assign bus.Lost      = (state == LOST);
    assign bus.ScoreTick = score_tick;
    assign bus.Score     = score;
    assign bus.HighScore = high_score;

endmodule
